fpu_issue_ctrl: RTL and testbench

//  Upstream issue stage for the single-precision add and subtract units.
//  - Queues op requests (opcode plus two IEEE-754 operands).
//  - Issues each request as a one-cycle valid pulse to the add unit or the sub unit.
//  - Waits for that unit's ready pulse, then returns the result on a valid/ready response port.
//  - Processes one op at a time, in order, with a timeout guard on each op.

---
 rtl/fpu_issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// In-order issue stage feeding single-precision add/sub units through a small request FIFO.
// Optional macro FPU_ISSUE_NAN_BYPASS_EN answers NaN-operand ops locally without starting a unit.
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_op,
  output logic        rsp_err,
  output logic [31:0] au_din1,
  output logic [31:0] au_din2,
  output logic        add_valid,
  output logic        sub_valid,
  input  logic [31:0] add_result,
  input  logic        add_ready,
  input  logic [31:0] sub_result,
  input  logic        sub_ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

`ifdef FPU_ISSUE_NAN_BYPASS_EN
  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction
`endif

  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [1:0]    mem_op [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          push;
  logic          pop;
  logic [31:0]   head_a;
  logic [31:0]   head_b;
  logic [1:0]    head_op;
  state_t        state;
  logic [1:0]    op_reg;
  logic [CW-1:0] tcnt;
  logic          unit_ready;
  logic [31:0]   unit_result;

  // FIFO handshake, head view and issued-unit selection
  always_comb begin
    push        = req_valid & req_ready;
    pop         = (state == S_IDLE) && (count != {(PW+1){1'b0}});
    head_a      = mem_a[rd_ptr];
    head_b      = mem_b[rd_ptr];
    head_op     = mem_op[rd_ptr];
    unit_ready  = op_reg[0] ? sub_ready : add_ready;
    unit_result = op_reg[0] ? sub_result : add_result;
    case ({push, pop})
      2'b10:   count_next = count + (PW+1)'(1);
      2'b01:   count_next = count - (PW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Request FIFO storage, pointers and registered ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= {PW{1'b0}};
      rd_ptr    <= {PW{1'b0}};
      count     <= {(PW+1){1'b0}};
      req_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i]  <= 32'd0;
        mem_b[i]  <= 32'd0;
        mem_op[i] <= 2'b00;
      end
    end else begin
      if (push) begin
        mem_a[wr_ptr]  <= req_a;
        mem_b[wr_ptr]  <= req_b;
        mem_op[wr_ptr] <= req_op;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count     <= count_next;
      req_ready <= (count_next != FULL_CNT);
    end
  end

  // Issue FSM: one op in flight, start pulses and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_reg     <= 2'b00;
      tcnt       <= {CW{1'b0}};
      au_din1    <= 32'd0;
      au_din2    <= 32'd0;
      add_valid  <= 1'b0;
      sub_valid  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_op     <= 2'b00;
      rsp_err    <= 1'b0;
    end else begin
      add_valid <= 1'b0;
      sub_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            au_din1 <= head_a;
            au_din2 <= head_b;
            op_reg  <= head_op;
            if (head_op[1]) begin
              rsp_result <= QNAN;
              rsp_err    <= 1'b1;
              rsp_op     <= head_op;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
`ifdef FPU_ISSUE_NAN_BYPASS_EN
            else if (is_nan(head_a) || is_nan(head_b)) begin
              rsp_result <= QNAN;
              rsp_err    <= 1'b0;
              rsp_op     <= head_op;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
`endif
            else begin
              state <= S_ISSUE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (op_reg[0]) begin
            sub_valid <= 1'b1;
          end else begin
            add_valid <= 1'b1;
          end
          tcnt  <= {CW{1'b0}};
          state <= S_WAIT;
        end
        S_WAIT: begin
          // a completion on the final count still beats the timeout
          if (unit_ready) begin
            rsp_result <= unit_result;
            rsp_err    <= 1'b0;
            rsp_op     <= op_reg;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (tcnt == TO_LAST) begin
            rsp_result <= QNAN;
            rsp_err    <= 1'b1;
            rsp_op     <= op_reg;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with behavioural add/sub unit stubs.
module tb_fpu_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_op;
  logic        rsp_err;
  logic [31:0] au_din1;
  logic [31:0] au_din2;
  logic        add_valid;
  logic        sub_valid;
  logic [31:0] add_result;
  logic        add_ready;
  logic [31:0] sub_result;
  logic        sub_ready;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_err(rsp_err), .au_din1(au_din1), .au_din2(au_din2),
    .add_valid(add_valid), .sub_valid(sub_valid),
    .add_result(add_result), .add_ready(add_ready),
    .sub_result(sub_result), .sub_ready(sub_ready)
  );

  typedef struct {
    logic [31:0] result;
    logic [1:0]  op;
    logic        err;
    int          add_p;
    int          sub_p;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int add_lat = 0;
  int sub_lat = 0;
  int spur_at = -1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'd0;

  int add_cnt = 0;
  int sub_cnt = 0;
  int last_pulse = 0;
  int rise_cyc = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_result = 32'd0;
  logic [1:0]  prev_op = 2'b00;
  logic        prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] r, input logic [1:0] op, input logic e,
                            input int ap, input int sp, input int lat);
    exp_t x;
    x.result = r; x.op = op; x.err = e; x.add_p = ap; x.sub_p = sp; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      check("req_accept", 32'(ok), 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: cycle count, pulse tracking, hold protocol and scoreboard compare
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        check("reset_outputs", 32'(|{rsp_valid, req_ready, rsp_result, rsp_op, rsp_err,
                                     au_din1, au_din2, add_valid, sub_valid}), 32'd0);
        exp_q.delete();
        add_cnt = 0; sub_cnt = 0; prev_valid = 1'b0;
      end else begin
        if (add_valid) begin add_cnt++; last_pulse = cyc; end
        if (sub_valid) begin sub_cnt++; last_pulse = cyc; end
        if (rsp_valid && !prev_valid) rise_cyc = cyc;
        if (prev_valid && !prev_ready) begin
          check("rsp_hold", {rsp_valid, rsp_err, rsp_op, 28'd0} ^ rsp_result,
                {1'b1, prev_err, prev_op, 28'd0} ^ prev_result);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_result", rsp_result, e.result);
            check("rsp_op", 32'(rsp_op), 32'(e.op));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("add_pulses", 32'(add_cnt), 32'(e.add_p));
            check("sub_pulses", 32'(sub_cnt), 32'(e.sub_p));
            if (e.lat >= 0) check("rsp_latency", 32'(rise_cyc - last_pulse), 32'(e.lat));
          end
          add_cnt = 0; sub_cnt = 0;
        end
        prev_valid = rsp_valid; prev_ready = rsp_ready;
        prev_result = rsp_result; prev_op = rsp_op; prev_err = rsp_err;
      end
    end
  end

  // Add/sub unit stubs: programmable latency, optional spurious add_ready
  initial begin : unit_model
    int acd;
    int scd;
    logic [31:0] ares;
    logic [31:0] sres;
    acd = 0; scd = 0; ares = 32'd0; sres = 32'd0;
    add_ready = 1'b0; sub_ready = 1'b0; add_result = 32'd0; sub_result = 32'd0;
    forever begin
      @(posedge clk); #1;
      add_ready = 1'b0; sub_ready = 1'b0;
      if (!reset) begin
        acd = 0; scd = 0;
      end else begin
        if (acd > 0) begin acd--; if (acd == 0) begin add_ready = 1'b1; add_result = ares; end end
        if (scd > 0) begin scd--; if (scd == 0) begin sub_ready = 1'b1; sub_result = sres; end end
        if (spur_at == cyc) begin add_ready = 1'b1; add_result = 32'hDEAD_BEEF; end
        if (add_valid) begin acd = add_lat; ares = ovr_en ? ovr_val : au_din1 + au_din2; end
        if (sub_valid) begin scd = sub_lat; sres = ovr_en ? ovr_val : au_din1 - au_din2; end
      end
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;

    // basic add with a 3-cycle unit
    ovr_en = 1'b1; ovr_val = 32'h4040_0000; add_lat = 3;
    expect_rsp(32'h4040_0000, 2'b00, 1'b0, 1, 0, 4);
    send(2'b00, 32'h3F80_0000, 32'h4000_0000);
    drain(100);
    ovr_en = 1'b0;

    // illegal opcode
    expect_rsp(QNAN, 2'b10, 1'b1, 0, 0, -1);
    send(2'b10, 32'h1234_5678, 32'h9ABC_DEF0);
    drain(100);

    // sub timeout with a spurious add_ready during WAIT
    sub_lat = 0;
    expect_rsp(QNAN, 2'b01, 1'b1, 0, 1, TIMEOUT);
    send(2'b01, 32'h4000_0000, 32'h3F80_0000);
    spur_at = cyc + 8;
    drain(300);
    spur_at = -1;

    // ready on the last timeout count completes normally
    sub_lat = TIMEOUT - 1;
    expect_rsp(32'h0000_0030, 2'b01, 1'b0, 0, 1, TIMEOUT);
    send(2'b01, 32'h0000_0050, 32'h0000_0020);
    drain(300);

    // fill the FIFO behind a stalled response; sixth request must be held
    add_lat = 2; sub_lat = 2; rsp_ready = 1'b0;
    expect_rsp(32'h0000_0013, 2'b00, 1'b0, 1, 0, 3);
    expect_rsp(32'h0000_000D, 2'b01, 1'b0, 0, 1, 3);
    expect_rsp(32'h0000_0300, 2'b00, 1'b0, 1, 0, 3);
    expect_rsp(32'hFFFF_FFFE, 2'b01, 1'b0, 0, 1, 3);
    expect_rsp(QNAN,          2'b11, 1'b1, 0, 0, -1);
    expect_rsp(32'h0000_0FFF, 2'b01, 1'b0, 0, 1, 3);
    send(2'b00, 32'h0000_0010, 32'h0000_0003);
    send(2'b01, 32'h0000_0010, 32'h0000_0003);
    send(2'b00, 32'h0000_0100, 32'h0000_0200);
    send(2'b01, 32'h0000_0005, 32'h0000_0007);
    send(2'b11, 32'h0000_0001, 32'h0000_0002);
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'h0000_1000; req_b = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(2'b01, 32'h0000_1000, 32'h0000_0001);
    drain(300);

    // response held for 10 cycles without rsp_ready
    rsp_ready = 1'b0;
    expect_rsp(32'h0000_0003, 2'b00, 1'b0, 1, 0, 3);
    send(2'b00, 32'h0000_0001, 32'h0000_0002);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain(100);

    // reset mid-WAIT discards in-flight and queued ops
    add_lat = 0;
    send(2'b00, 32'h0000_0007, 32'h0000_0008);
    send(2'b01, 32'h0000_0009, 32'h0000_0001);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    add_lat = 2;
    repeat (30) @(negedge clk);
    check("req_ready_after_reset", 32'(req_ready), 32'd1);
    check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // NaN operand: bypassed locally when enabled, otherwise issued
    ovr_en = 1'b1; ovr_val = 32'h7FC0_0001;
`ifdef FPU_ISSUE_NAN_BYPASS_EN
    expect_rsp(QNAN, 2'b00, 1'b0, 0, 0, -1);
`else
    expect_rsp(32'h7FC0_0001, 2'b00, 1'b0, 1, 0, 3);
`endif
    send(2'b00, 32'h7FC0_0001, 32'h3F80_0000);
    drain(100);
    ovr_en = 1'b0;

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
